sigmoid_pwl_pipe: RTL and testbench
===================================

Name: sigmoid_pwl_pipe

Overview:
Pipelined, multi-lane sigmoid/tanh activation unit for Q4.12 signed fixed-point data (16-bit, 12 fractional bits).
- Replaces exact-match table lookup with piecewise-linear interpolation over 29 breakpoints spanning [-7, 7] in 0.5 steps, so every input code gets a graded output.
- Adds a per-transaction tanh mode, valid/ready streaming with backpressure, and a saturation flag.
- Sits between the MAC accumulator output and the next layer's input buffer.

Parameters:
- LANES, 1, number of parallel independent channels sharing one handshake.
- INTERP, 1, 1 = linear interpolation between breakpoints; 0 = lower breakpoint value only (no multiplier).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_x  in  16*LANES  Q4.12 signed inputs; lane i = bits [16i+15:16i].
- in_mode  in  1  0 = sigmoid, 1 = tanh; applies to all lanes of the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_y  out  16*LANES  Q4.12 signed results, same lane packing.
- out_sat  out  LANES  per-lane flag: input was clamped (outside [-7, 7] after tanh prescale).

Behaviour:
- One clock and one reset. Reset is synchronous and active-high.
- Reset: all stage valid bits = 0, out_valid = 0, out_y = 0, out_sat = 0. Reset mid-stream discards all in-flight beats. in_ready = 1 in the cycle after reset deasserts.
- Breakpoint table T[k], k = 0..28, x = -7 + 0.5k. It is a hardcoded constant (round(4096*sigmoid(x))):
  - k = 0..13: 4, 6, 10, 17, 27, 45, 74, 120, 194, 311, 488, 747, 1102, 1546
  - k = 14: 2048
  - k = 15..28: 2550, 2994, 3349, 3608, 3785, 3902, 3976, 4022, 4051, 4069, 4079, 4086, 4090, 4092
- Pipeline: 3 stages, fixed latency 3 accepted cycles. Global stall model:
  - advance = !out_valid | out_ready
  - in_ready = advance
  - All stages shift only when advance = 1. A beat is accepted when in_valid & in_ready.
- Output hold: out_y, out_sat, out_valid hold stable while out_valid & !out_ready.
- Full throughput: one beat per cycle when out_ready stays high. No reordering.
- Stage 1 (prescale/clamp):
  - tanh mode: xs = saturating 2*x in 16 bits (clamp to 0x7FFF / 0x8000). Sigmoid mode: xs = x.
  - Clamp xs to [-28672, 28672] (±7.0). sat = 1 iff xs is strictly outside that range.
  - u = xs_clamped + 28672 (unsigned 0..57344). idx = u >> 11 (0..28). frac = u[10:0].
- Stage 2 (lookup/multiply):
  - lo = T[idx]. hi = T[idx+1], except when idx = 28, where hi = lo.
  - p = (hi - lo) * frac. Unsigned; diff ≤ 502, so 20 bits suffice.
  - INTERP = 0: p forced to 0.
- Stage 3 (combine):
  - s = lo + (p >> 11), truncating toward zero.
  - Sigmoid: y = s, range 4..4092.
  - tanh: y = 2*s - 4096, signed, range -4088..4088.
- Registered outputs: out_y, out_sat, out_valid. in_mode travels with the beat.
- Lanes are fully independent. Mode and handshake are shared.
- Simultaneous accept and emit in the same cycle is legal and loses no data.

Test Plan:
1. Sigmoid, LANES=1. Stream x = 0x0000, 0x1000, 0xF000 with out_ready=1 -> out_y = 2048, 2994, 1102, with out_valid exactly 3 cycles after each accept. out_sat = 0.
2. Interpolation. x = 0x0400 (0.25) -> 2299. Same input with INTERP=0 -> 2048. x = 0x7000 (7.0) -> 4092, sat = 0.
3. Saturation. x = 0x7FFF -> 4092, sat = 1. x = 0x8000 -> 4, sat = 1. x = 0x9000 (-7.0) -> 4, sat = 0.
4. tanh, in_mode=1:
   - x = 0x1000 -> 3120.
   - x = 0x0000 -> 0.
   - x = 0xF000 -> -3120 (0xF3D0).
   - x = 0x4000 -> 4088, sat = 1 (2x = 8.0).
5. Backpressure. Send 6 beats back-to-back. Hold out_ready=0 for 4 cycles mid-stream -> in_ready drops, out_y held stable, all 6 results emerge in order with none lost or duplicated.
6. LANES=4 and reset. Lanes = {0x1000, 0x0000, 0x7FFF, 0xF000} -> {2994, 2048, 4092, 1102}, sat = 0b0100. Then assert rst with 2 beats in flight -> out_valid = 0 the next cycle and those beats never appear.

Source files
------------

// File: rtl/sigmoid_pwl_pipe_if.sv
// Streaming interface for the sigmoid/tanh activation unit.
// Input side : in_valid/in_ready handshake, in_x (Q4.12 per lane), in_mode (0 sigmoid, 1 tanh).
// Output side: out_valid/out_ready handshake, out_y (Q4.12 per lane), out_sat (per-lane clamp flag).
// Lane i occupies bits [16i+15:16i] of in_x / out_y.
interface sigmoid_pwl_pipe_if #(
  parameter int LANES = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [16*LANES-1:0]   in_x;
  logic                  in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [16*LANES-1:0]   out_y;
  logic [LANES-1:0]      out_sat;

  // Upstream/downstream side that feeds beats in and drains results.
  modport master (
    output in_valid, in_x, in_mode, out_ready,
    input  in_ready, out_valid, out_y, out_sat
  );

  // The activation unit itself.
  modport slave (
    input  in_valid, in_x, in_mode, out_ready,
    output in_ready, out_valid, out_y, out_sat
  );
endinterface

// File: rtl/sigmoid_pwl_pipe.sv
// Pipelined multi-lane sigmoid/tanh unit, Q4.12 signed fixed point.
// Piecewise-linear interpolation over 29 breakpoints on [-7, 7] in 0.5 steps.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears all in-flight beats
//   bus  - sigmoid_pwl_pipe_if slave: valid/ready input and output streams
// Three stages (prescale/clamp, lookup/multiply, combine) share one stall
// signal: everything shifts when the output register is empty or drained.
module sigmoid_pwl_pipe #(
  parameter int LANES  = 1,
  parameter int INTERP = 1
) (
  input logic              clk,
  input logic              rst,
  sigmoid_pwl_pipe_if.slave bus
);

  localparam logic signed [15:0] XMAX = 16'sd28672;
  localparam logic signed [15:0] XMIN = -16'sd28672;
  localparam logic        [15:0] XOFS = 16'd28672;

  // round(4096 * sigmoid(-7 + 0.5k)); codes past 28 are never used as a lower point.
  function automatic logic [11:0] bp_f(input logic [4:0] k);
    case (k)
      5'd0:  bp_f = 12'd4;
      5'd1:  bp_f = 12'd6;
      5'd2:  bp_f = 12'd10;
      5'd3:  bp_f = 12'd17;
      5'd4:  bp_f = 12'd27;
      5'd5:  bp_f = 12'd45;
      5'd6:  bp_f = 12'd74;
      5'd7:  bp_f = 12'd120;
      5'd8:  bp_f = 12'd194;
      5'd9:  bp_f = 12'd311;
      5'd10: bp_f = 12'd488;
      5'd11: bp_f = 12'd747;
      5'd12: bp_f = 12'd1102;
      5'd13: bp_f = 12'd1546;
      5'd14: bp_f = 12'd2048;
      5'd15: bp_f = 12'd2550;
      5'd16: bp_f = 12'd2994;
      5'd17: bp_f = 12'd3349;
      5'd18: bp_f = 12'd3608;
      5'd19: bp_f = 12'd3785;
      5'd20: bp_f = 12'd3902;
      5'd21: bp_f = 12'd3976;
      5'd22: bp_f = 12'd4022;
      5'd23: bp_f = 12'd4051;
      5'd24: bp_f = 12'd4069;
      5'd25: bp_f = 12'd4079;
      5'd26: bp_f = 12'd4086;
      5'd27: bp_f = 12'd4090;
      5'd28: bp_f = 12'd4092;
      default: bp_f = 12'd0;
    endcase
  endfunction

  // Returns {sat, u}: tanh doubles x (saturating), then clamp to +-7.0 and
  // bias to an unsigned 0..57344 so u[15:11] is the segment and u[10:0] the fraction.
  function automatic logic [16:0] prescale_f(input logic [15:0] x, input logic mode);
    logic [15:0] xs;
    logic [15:0] xc;
    logic        sat;
    if (mode) begin
      if (x[15] != x[14]) xs = x[15] ? 16'h8000 : 16'h7FFF;
      else                xs = {x[14:0], 1'b0};
    end else begin
      xs = x;
    end
    if ($signed(xs) > XMAX) begin
      xc  = XMAX;
      sat = 1'b1;
    end else if ($signed(xs) < XMIN) begin
      xc  = XMIN;
      sat = 1'b1;
    end else begin
      xc  = xs;
      sat = 1'b0;
    end
    prescale_f = {sat, xc + XOFS};
  endfunction

  // Returns {lo, p}; the last segment has no upper neighbour so its slope is zero.
  function automatic logic [31:0] lookup_f(input logic [4:0] idx, input logic [10:0] frac);
    logic [11:0] lo;
    logic [11:0] hi;
    logic [11:0] diff;
    logic [19:0] p;
    lo = bp_f(idx);
    if (idx == 5'd28) hi = lo;
    else              hi = bp_f(idx + 5'd1);
    diff = hi - lo;
    if (INTERP != 32'sd0) p = {8'd0, diff} * {9'd0, frac};
    else                  p = 20'd0;
    lookup_f = {lo, p};
  endfunction

  // Sigmoid result directly, or tanh(x) = 2*sigmoid(2x) - 1 in Q4.12.
  function automatic logic [15:0] combine_f(input logic [11:0] lo, input logic [19:0] p,
                                            input logic mode);
    logic [12:0] s;
    logic [15:0] s16;
    s   = {1'b0, lo} + {4'd0, p[19:11]};
    s16 = {3'd0, s};
    if (mode) combine_f = {s16[14:0], 1'b0} - 16'd4096;
    else      combine_f = s16;
  endfunction

  logic              adv_s;
  logic [15:0]       u1_s   [LANES];
  logic [LANES-1:0]  sat1_s;
  logic [11:0]       lo2_s  [LANES];
  logic [19:0]       p2_s   [LANES];
  logic [16*LANES-1:0] y3_s;

  logic              v1_r;
  logic              mode1_r;
  logic [4:0]        idx1_r  [LANES];
  logic [10:0]       frac1_r [LANES];
  logic [LANES-1:0]  sat1_r;

  logic              v2_r;
  logic              mode2_r;
  logic [11:0]       lo2_r   [LANES];
  logic [19:0]       p2_r    [LANES];
  logic [LANES-1:0]  sat2_r;

  logic              out_valid_r;
  logic [16*LANES-1:0] out_y_r;
  logic [LANES-1:0]  out_sat_r;

  assign adv_s         = !out_valid_r | bus.out_ready;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_y     = out_y_r;
  assign bus.out_sat   = out_sat_r;

  // Stage 1 datapath: prescale, clamp, split into segment index and fraction.
  always_comb begin
    sat1_s = '0;
    for (int i = 0; i < LANES; i++) begin
      {sat1_s[i], u1_s[i]} = prescale_f(bus.in_x[16*i +: 16], bus.in_mode);
    end
  end

  // Stage 2 datapath: breakpoint lookup and slope * fraction.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      {lo2_s[i], p2_s[i]} = lookup_f(idx1_r[i], frac1_r[i]);
    end
  end

  // Stage 3 datapath: add interpolated offset and apply tanh rescale.
  always_comb begin
    y3_s = '0;
    for (int i = 0; i < LANES; i++) begin
      y3_s[16*i +: 16] = combine_f(lo2_r[i], p2_r[i], mode2_r);
    end
  end

  // Pipeline registers; all stages move together under the shared stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r        <= 1'b0;
      mode1_r     <= 1'b0;
      sat1_r      <= '0;
      v2_r        <= 1'b0;
      mode2_r     <= 1'b0;
      sat2_r      <= '0;
      out_valid_r <= 1'b0;
      out_y_r     <= '0;
      out_sat_r   <= '0;
      for (int i = 0; i < LANES; i++) begin
        idx1_r[i]  <= 5'd0;
        frac1_r[i] <= 11'd0;
        lo2_r[i]   <= 12'd0;
        p2_r[i]    <= 20'd0;
      end
    end else if (adv_s) begin
      v1_r        <= bus.in_valid;
      mode1_r     <= bus.in_mode;
      sat1_r      <= sat1_s;
      v2_r        <= v1_r;
      mode2_r     <= mode1_r;
      sat2_r      <= sat1_r;
      out_valid_r <= v2_r;
      out_y_r     <= y3_s;
      out_sat_r   <= sat2_r;
      for (int i = 0; i < LANES; i++) begin
        idx1_r[i]  <= u1_s[i][15:11];
        frac1_r[i] <= u1_s[i][10:0];
        lo2_r[i]   <= lo2_s[i];
        p2_r[i]    <= p2_s[i];
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
module tb_sigmoid_pwl_pipe;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;

  typedef struct {
    logic [63:0] y;
    logic [3:0]  sat;
    int          tag;
    bit          lat;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  exp_t q4[$];

  logic        hold1;
  logic [63:0] hy1;
  logic [63:0] hs1;

  sigmoid_pwl_pipe_if #(.LANES(1)) if1 ();
  sigmoid_pwl_pipe_if #(.LANES(1)) if0 ();
  sigmoid_pwl_pipe_if #(.LANES(4)) if4 ();

  sigmoid_pwl_pipe #(.LANES(1), .INTERP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  sigmoid_pwl_pipe #(.LANES(1), .INTERP(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  sigmoid_pwl_pipe #(.LANES(4), .INTERP(1)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  // The no-interpolation unit sees exactly the same stream as the main one.
  assign if0.in_valid  = if1.in_valid;
  assign if0.in_x      = if1.in_x;
  assign if0.in_mode   = if1.in_mode;
  assign if0.out_ready = if1.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor for the interpolating single-lane unit, plus hold-stability check.
  always @(negedge clk) begin
    exp_t e;
    if (hold1 && !rst) begin
      chk("hold_valid", 64'(if1.out_valid), 64'd1);
      chk("hold_y", 64'(if1.out_y), hy1);
      chk("hold_sat", 64'(if1.out_sat), hs1);
    end
    hold1 = !rst && (if1.out_valid === 1'b1) && (if1.out_ready === 1'b0);
    hy1   = 64'(if1.out_y);
    hs1   = 64'(if1.out_sat);
    if (!rst && if1.out_valid === 1'b1 && if1.out_ready === 1'b1) begin
      chk("q1_expected_beat", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("y1", 64'(if1.out_y), e.y);
        chk("sat1", 64'(if1.out_sat), 64'(e.sat));
        if (e.lat) chk("latency1", 64'(cyc - e.tag), 64'd3);
      end
    end
  end

  // Output monitor for the INTERP=0 unit.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && if0.out_valid === 1'b1 && if0.out_ready === 1'b1) begin
      chk("q0_expected_beat", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("y0", 64'(if0.out_y), e.y);
        chk("sat0", 64'(if0.out_sat), 64'(e.sat));
      end
    end
  end

  // Output monitor for the four-lane unit.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && if4.out_valid === 1'b1 && if4.out_ready === 1'b1) begin
      chk("q4_expected_beat", 64'(q4.size() != 0), 64'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("y4", if4.out_y, e.y);
        chk("sat4", 64'(if4.out_sat), 64'(e.sat));
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send1(input logic [15:0] x, input logic m, input logic [15:0] ey,
                       input logic es, input logic [15:0] ey0, input bit lat);
    int   n;
    exp_t e;
    if1.in_valid = 1'b1;
    if1.in_x     = x;
    if1.in_mode  = m;
    n = 0;
    @(negedge clk);
    while (if1.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept1_wait", 64'(n < 50), 64'd1);
    e.y = 64'(ey); e.sat = 4'(es); e.tag = cyc; e.lat = lat;
    q1.push_back(e);
    e.y = 64'(ey0);
    q0.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic send4(input logic [63:0] x, input logic [63:0] ey, input logic [3:0] es,
                       input bit push);
    int   n;
    exp_t e;
    if4.in_valid = 1'b1;
    if4.in_x     = x;
    if4.in_mode  = 1'b0;
    n = 0;
    @(negedge clk);
    while (if4.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept4_wait", 64'(n < 50), 64'd1);
    e.y = ey; e.sat = es; e.tag = cyc; e.lat = 1'b0;
    if (push) q4.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    if1.in_valid = 1'b0;
    if4.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q1.size() + q0.size() + q4.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(q1.size() + q0.size() + q4.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; cyc = 0; hold1 = 1'b0; hy1 = '0; hs1 = '0;
    rst = 1'b1;
    if1.in_valid = 1'b0; if1.in_x = 16'd0; if1.in_mode = 1'b0; if1.out_ready = 1'b0;
    if4.in_valid = 1'b0; if4.in_x = 64'd0; if4.in_mode = 1'b0; if4.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(if1.out_valid), 64'd0);
    chk("rst_out_y", 64'(if1.out_y), 64'd0);
    chk("rst_out_sat", 64'(if1.out_sat), 64'd0);
    chk("rst_out_valid4", 64'(if4.out_valid), 64'd0);
    chk("rst_out_y4", if4.out_y, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_rst", 64'(if1.in_ready), 64'd1);
    @(posedge clk); #1;
    if1.out_ready = 1'b1;

    // 1: sigmoid stream with latency check
    send1(16'h0000, 1'b0, 16'd2048, 1'b0, 16'd2048, 1'b1);
    send1(16'h1000, 1'b0, 16'd2994, 1'b0, 16'd2994, 1'b1);
    send1(16'hF000, 1'b0, 16'd1102, 1'b0, 16'd1102, 1'b1);
    idle();
    drain("drain_t1");

    // 2: interpolation and upper edge
    send1(16'h0400, 1'b0, 16'd2299, 1'b0, 16'd2048, 1'b0);
    send1(16'h7000, 1'b0, 16'd4092, 1'b0, 16'd4092, 1'b0);
    // 3: saturation
    send1(16'h7FFF, 1'b0, 16'd4092, 1'b1, 16'd4092, 1'b0);
    send1(16'h8000, 1'b0, 16'd4,    1'b1, 16'd4,    1'b0);
    send1(16'h9000, 1'b0, 16'd4,    1'b0, 16'd4,    1'b0);
    // 4: tanh
    send1(16'h1000, 1'b1, 16'h0C30, 1'b0, 16'h0C30, 1'b0);
    send1(16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
    send1(16'hF000, 1'b1, 16'hF3D0, 1'b0, 16'hF3D0, 1'b0);
    send1(16'h4000, 1'b1, 16'd4088, 1'b1, 16'd4088, 1'b0);
    idle();
    drain("drain_t2_4");

    // 5: backpressure with six back-to-back beats
    fork
      begin
        send1(16'h0C00, 1'b0, 16'd2772, 1'b0, 16'd2550, 1'b0);
        send1(16'hFC00, 1'b0, 16'd1797, 1'b0, 16'd1546, 1'b0);
        send1(16'h0100, 1'b0, 16'd2110, 1'b0, 16'd2048, 1'b0);
        send1(16'h2300, 1'b0, 16'd3674, 1'b0, 16'd3608, 1'b0);
        send1(16'h0200, 1'b1, 16'd502,  1'b0, 16'd0,    1'b0);
        send1(16'hE000, 1'b0, 16'd488,  1'b0, 16'd488,  1'b0);
        idle();
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (if1.out_valid !== 1'b1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("bp_first_output", 64'(n < 20), 64'd1);
        @(posedge clk); #1;
        if1.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_in_ready_low", 64'(if1.in_ready), 64'd0);
        end
        @(posedge clk); #1;
        if1.out_ready = 1'b1;
      end
    join
    drain("drain_t5");

    // 6: four lanes, then reset with two beats in flight
    send4({16'hF000, 16'h7FFF, 16'h0000, 16'h1000},
          {16'd1102, 16'd4092, 16'd2048, 16'd2994}, 4'b0100, 1'b1);
    idle();
    drain("drain_t6");
    send4({16'h1000, 16'h1000, 16'h1000, 16'h1000}, 64'd0, 4'd0, 1'b0);
    send4({16'h0000, 16'h0000, 16'h0000, 16'h0000}, 64'd0, 4'd0, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid4", 64'(if4.out_valid), 64'd0);
    chk("midrst_out_y4", if4.out_y, 64'd0);
    chk("midrst_out_sat4", 64'(if4.out_sat), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready4_after_rst", 64'(if4.in_ready), 64'd1);
    repeat (10) @(negedge clk);
    chk("flushed_beats_absent", 64'(q4.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
